// File: rtl/bit_serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial full-add cell between two requesters.
// Each granted add is processed LSB-first, one bit per clock, with a registered carry.
module bit_serial_add_scheduler #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             id;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    count;
  logic             grant;
  logic             accept;
  logic             cell_sum;
  logic             cell_co;

  // Reduced full-add cell: propagate as OR is sufficient for the carry term.
  function automatic logic [1:0] full_add_cell(input logic a, input logic b, input logic ci);
    logic cp;
    logic cg;
    cp = a | b;
    cg = a & b;
    return {cg | (cp & ci), a ^ b ^ ci};
  endfunction

  always_comb begin
    grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    accept     = req0_ready || req1_ready;
    {cell_co, cell_sum} = full_add_cell(a_sr[0], b_sr[0], carry);
    sum_next   = sum_reg >> 1;
    sum_next[WIDTH-1] = cell_sum;
  end

  assign rsp_sum = sum_reg;
  assign rsp_co  = carry;
  assign rsp_id  = id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      id        <= 1'b0;
      carry     <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_reg   <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr   <= grant ? req1_a : req0_a;
            b_sr   <= grant ? req1_b : req0_b;
            carry  <= grant ? req1_ci : req0_ci;
            count  <= '0;
            id     <= grant;
            rr_ptr <= ~grant;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sum_reg <= sum_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry   <= cell_co;
          count   <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_add_scheduler.sv
// Directed and randomized bench for bit_serial_add_scheduler (WIDTH=8 and WIDTH=1 instances)
// with a response scoreboard fed at request handshakes.
module tb_bit_serial_add_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ci = 1'b0, req1_ci = 1'b0;
  logic         rsp_valid, rsp_id, rsp_co, busy;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;

  logic       w1_req0_valid = 1'b0, w1_req1_valid = 1'b0;
  logic       w1_req0_ready, w1_req1_ready;
  logic [0:0] w1_req0_a = '0, w1_req0_b = '0, w1_req1_a = '0, w1_req1_b = '0;
  logic       w1_req0_ci = 1'b0, w1_req1_ci = 1'b0;
  logic       w1_rsp_valid, w1_rsp_id, w1_rsp_co, w1_busy;
  logic       w1_rsp_ready = 1'b1;
  logic [0:0] w1_rsp_sum;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic         gq[$];

  always #5 clk = ~clk;

  bit_serial_add_scheduler #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_co(rsp_co),
    .busy(busy)
  );

  bit_serial_add_scheduler #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_a(w1_req0_a), .req0_b(w1_req0_b),
    .req0_ci(w1_req0_ci),
    .req1_valid(w1_req1_valid), .req1_ready(w1_req1_ready), .req1_a(w1_req1_a), .req1_b(w1_req1_b),
    .req1_ci(w1_req1_ci),
    .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready), .rsp_id(w1_rsp_id), .rsp_sum(w1_rsp_sum),
    .rsp_co(w1_rsp_co), .busy(w1_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard sampling on the falling edge, then advance past the next rising edge.
  task automatic tick();
    logic [W+1:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req0_ci)});
        gq.push_back(1'b0);
        acc_cnt++;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req1_ci)});
        gq.push_back(1'b1);
        acc_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL sb_unexpected_rsp observed=%0h expected=none", {rsp_id, rsp_co, rsp_sum});
        end else begin
          e = exp_q.pop_front();
          chk("sb_rsp", {rsp_id, rsp_co, rsp_sum}, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic who, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int waits);
    waits = 0;
    if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ci = ci; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ci = ci; end
    #1;
    while (!(who ? req1_ready : req0_ready) && waits < 100) begin
      tick();
      waits++;
    end
    if (waits >= 100) chk("req_timeout", waits, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("idle_timeout", n, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int w;
    logic hs0, hs1;
    int cyc;

    // Reset state, with a requester already asserting valid.
    req0_valid = 1'b1;
    #2;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_fields", {rsp_id, rsp_co, rsp_sum}, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add and latency.
    req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h3C; req0_ci = 1'b0;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t1_ready_drop", req0_ready, 0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < W - 1; i++) tick();
    chk("t1_valid_early", rsp_valid, 0);
    tick();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_result", {rsp_id, rsp_co, rsp_sum}, {1'b0, 1'b0, 8'h96});
    tick();
    chk("t1_idle_busy", busy, 0);

    // Carry ripple cases on requester 1.
    do_req(1'b1, 8'hFF, 8'h01, 1'b0, w); wait_idle();
    do_req(1'b1, 8'hFF, 8'h00, 1'b1, w); wait_idle();
    do_req(1'b1, 8'h80, 8'h80, 1'b1, w); wait_idle();
    chk("t2_queue_empty", exp_q.size(), 0);

    // Fairness with both requesters continuously valid.
    do_reset();
    gq.delete();
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_ci = 1'b1;
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h20; req1_ci = 1'b0;
    cyc = 0;
    while (gq.size() < 4 && cyc < 200) begin
      tick();
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t3_grant_count", gq.size(), 4);
    if (gq.size() >= 4) chk("t3_grant_order", {gq[0], gq[1], gq[2], gq[3]}, 4'b0101);
    wait_idle();
    do_req(1'b1, 8'h0F, 8'h01, 1'b0, w);
    chk("t3_lone_req1_wait", w, 0);
    wait_idle();

    // Backpressure in DONE.
    rsp_ready = 1'b0;
    do_req(1'b0, 8'hA5, 8'h5A, 1'b1, w);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin tick(); cyc++; end
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_ci = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h02; req1_ci = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rsp", {rsp_valid, rsp_id, rsp_co, rsp_sum}, {1'b1, 1'b0, 1'b1, 8'h00});
      chk("t4_readys", {req0_ready, req1_ready}, 2'b00);
      chk("t4_busy", busy, 1);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("t4_release", {rsp_valid, busy}, 2'b00);

    // Asynchronous reset in the fourth SHIFT cycle.
    do_req(1'b0, 8'h55, 8'h55, 1'b0, w);
    tick(); tick(); tick();
    req0_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_outputs", {rsp_valid, busy, rsp_id, rsp_co, rsp_sum, req0_ready, req1_ready}, 0);
    exp_q.delete();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_req(1'b0, 8'h12, 8'h34, 1'b0, w);
    chk("t5_post_reset_wait", w, 0);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin tick(); cyc++; end
    chk("t5_result", {rsp_id, rsp_co, rsp_sum}, {1'b0, 1'b0, 8'h46});
    wait_idle();

    // Randomized sweep against the scoreboard.
    acc_cnt = 0;
    rsp_cnt = 0;
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 40000) begin
      if (!req0_valid && $urandom_range(0, 3) != 0) begin
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_ci = 1'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 3) != 0) begin
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_ci = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      tick();
      if (hs0) req0_valid = 1'b0;
      if (hs1) req1_valid = 1'b0;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("t6_accepted", acc_cnt, 1000);
    chk("t6_no_loss_dup", rsp_cnt, acc_cnt);
    chk("t6_queue_empty", exp_q.size(), 0);

    // WIDTH=1 instance: one SHIFT cycle.
    w1_req0_valid = 1'b1; w1_req0_a = 1'b1; w1_req0_b = 1'b1; w1_req0_ci = 1'b1;
    #1;
    chk("w1_ready0", w1_req0_ready, 1);
    tick();
    w1_req0_valid = 1'b0;
    chk("w1_shift_valid", w1_rsp_valid, 0);
    tick();
    chk("w1_result_111", {w1_rsp_valid, w1_rsp_id, w1_rsp_co, w1_rsp_sum}, 4'b1011);
    tick();
    chk("w1_idle", {w1_rsp_valid, w1_busy}, 2'b00);
    w1_req1_valid = 1'b1; w1_req1_a = 1'b0; w1_req1_b = 1'b1; w1_req1_ci = 1'b0;
    #1;
    chk("w1_ready1", w1_req1_ready, 1);
    tick();
    w1_req1_valid = 1'b0;
    tick();
    chk("w1_result_010", {w1_rsp_valid, w1_rsp_id, w1_rsp_co, w1_rsp_sum}, 4'b1101);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
